pipe_fetch: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the five-stage pipelined MIPS computer. It owns the PC and issues fetches to instruction memory through a req/ack handshake that tolerates wait states. It applies next-PC redirects produced by the decode-stage control unit (`pcsource`, one branch delay slot) and honours the decode-stage load-use stall. It delivers `dinst`/`dpc4`/`dvalid` to the decode stage, inserting bubbles (NOPs) whenever no fetched instruction is ready.

---
 rtl/pipe_fetch_if.sv | 11 +
 rtl/pipe_fetch.sv | 111 +++++++++++
 tb/tb_pipe_fetch.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_fetch_if.sv
// Instruction-memory fetch channel: req/addr out, ack/rdata back.
// The ack may be combinational on req (zero-wait memory).
interface pipe_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pipe_fetch.sv
// Fetch stage plus IF/ID register: owns the PC, fetches over a wait-state
// tolerant handshake, applies delayed-branch redirects and load-use stalls.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               stall,
    input  logic [1:0]         pcsource,
    input  logic [31:0]        bpc,
    input  logic [31:0]        rpc,
    input  logic [31:0]        jpc,
    pipe_fetch_if.master       imem,
    output logic [31:0]        pc,
    output logic [31:0]        dinst,
    output logic [31:0]        dpc4,
    output logic               dvalid
);
    typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_dinst, r_dpc4, r_sk_inst, r_redir_pc;
    logic        r_dvalid, r_redir_pend;

    logic        w_deliver, w_redir;
    logic [31:0] w_word, w_target, w_pc4, w_npc;

    assign w_pc4     = r_pc + 32'd4;
    assign w_deliver = ~stall & ((r_state == S_FETCH) ? imem.imem_ack : 1'b1);
    assign w_word    = (r_state == S_HOLD) ? r_sk_inst : imem.imem_rdata;
    // The instruction currently in ID is a taken branch/jump leaving this cycle.
    assign w_redir   = r_dvalid & ~stall & (pcsource != 2'b00);

    always_comb begin
        w_target = w_pc4;
        case (pcsource)
            2'b01:   w_target = bpc;
            2'b10:   w_target = rpc;
            2'b11:   w_target = jpc;
            default: w_target = w_pc4;
        endcase
    end

    always_comb begin
        w_npc = w_pc4;
        if (w_redir)           w_npc = w_target;
        else if (r_redir_pend) w_npc = r_redir_pc;
    end

    // FSM: state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_FETCH;
        else         r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (imem.imem_ack && stall) w_state_nxt = S_HOLD;
            S_HOLD:  if (!stall)                 w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // FSM: outputs
    always_comb begin
        imem.imem_req  = (r_state == S_FETCH);
        imem.imem_addr = r_pc;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc         <= RESET_PC;
            r_dinst      <= 32'h0;
            r_dpc4       <= 32'h0;
            r_dvalid     <= 1'b0;
            r_sk_inst    <= 32'h0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'h0;
        end else begin
            if (w_deliver) begin
                r_pc     <= w_npc;
                r_dinst  <= w_word;
                r_dpc4   <= w_pc4;
                r_dvalid <= 1'b1;
            end else if (!stall) begin
                // Fetch still waiting on memory: push a bubble into ID.
                r_dinst  <= 32'h0;
                r_dpc4   <= 32'h0;
                r_dvalid <= 1'b0;
            end

            if (r_state == S_FETCH && imem.imem_ack && stall)
                r_sk_inst <= imem.imem_rdata;

            // Target waits here until the delay slot is delivered.
            if (w_deliver) begin
                r_redir_pend <= 1'b0;
            end else if (w_redir) begin
                r_redir_pend <= 1'b1;
                r_redir_pc   <= w_target;
            end
        end
    end

    assign pc     = r_pc;
    assign dinst  = r_dinst;
    assign dpc4   = r_dpc4;
    assign dvalid = r_dvalid;
endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: memory model returns ~addr after a
// programmable number of wait cycles; ID redirects when it sees a chosen PC.
module tb_pipe_fetch;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsource;
    logic [31:0] bpc = 32'h100, rpc = 32'h200, jpc = 32'h300;
    logic [31:0] pc, dinst, dpc4;
    logic        dvalid;

    logic [3:0]  wait_n = 4'd0;
    logic [3:0]  r_cnt;
    logic        br_en = 1'b0;
    logic [1:0]  br_sel = 2'b00;
    logic [31:0] br_addr = 32'h20;

    int n_chk = 0;
    int n_fail = 0;

    pipe_fetch_if u_if ();

    pipe_fetch #(.RESET_PC(32'h0)) dut (
        .clock(clock), .resetn(resetn), .stall(stall), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem(u_if),
        .pc(pc), .dinst(dinst), .dpc4(dpc4), .dvalid(dvalid)
    );

    always #5 clock = ~clock;

    // Memory: ack after wait_n cycles of continuous request; ack dropped on reset.
    always @(posedge clock or negedge resetn) begin
        if (!resetn)                            r_cnt <= 4'd0;
        else if (!u_if.imem_req || u_if.imem_ack) r_cnt <= 4'd0;
        else                                    r_cnt <= r_cnt + 4'd1;
    end
    assign u_if.imem_ack   = resetn && u_if.imem_req && (r_cnt == wait_n);
    assign u_if.imem_rdata = ~u_if.imem_addr;

    // Decode-stage control unit stand-in.
    assign pcsource = (br_en && dvalid && dinst == ~br_addr) ? br_sel : 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] w);
        resetn = 1'b0;
        stall  = 1'b0;
        br_en  = 1'b0;
        wait_n = w;
        tick();
        resetn = 1'b1;
    endtask

    task automatic do_branch(input logic [3:0] w, input logic [1:0] sel, input logic [31:0] tgt);
        logic [31:0] exp [12];
        int n = 0;
        for (int i = 0; i < 9; i++) exp[i] = 32'(4 * i);
        exp[9]  = 32'h24;
        exp[10] = tgt;
        exp[11] = tgt + 32'd4;
        do_reset(w);
        br_sel = sel;
        br_en  = 1'b1;
        for (int c = 0; c < 300 && n < 12; c++) begin
            tick();
            if (dvalid) begin
                chk("br_seq", dinst, ~exp[n]);
                if (n == 9) chk("br_pc_tgt", pc, tgt);
                n++;
            end
        end
        chk("br_timeout", 32'(n), 32'd12);
        br_en = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_dvalid", {31'b0, dvalid}, 32'h0);
        chk("rst_dinst", dinst, 32'h0);
        chk("rst_dpc4", dpc4, 32'h0);

        // Zero-wait streaming
        do_reset(4'd0);
        chk("zw_req", {31'b0, u_if.imem_req}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("zw_dinst", dinst, ~32'(4 * k));
            chk("zw_dpc4", dpc4, 32'(4 * k + 4));
            chk("zw_dvalid", {31'b0, dvalid}, 32'h1);
            chk("zw_pc", pc, 32'(4 * k + 4));
        end

        // Two wait cycles per fetch
        do_reset(4'd2);
        for (int j = 0; j < 3; j++) begin
            for (int w = 0; w < 3; w++) begin
                chk("ws_addr", u_if.imem_addr, 32'(4 * j));
                tick();
                if (w < 2) begin
                    chk("ws_bub_v", {31'b0, dvalid}, 32'h0);
                    chk("ws_bub_i", dinst, 32'h0);
                end else begin
                    chk("ws_v", {31'b0, dvalid}, 32'h1);
                    chk("ws_i", dinst, ~32'(4 * j));
                end
            end
        end

        // Ack under stall at pc=0x10
        do_reset(4'd0);
        repeat (4) tick();
        chk("st_pc0", pc, 32'h10);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("st_req", {31'b0, u_if.imem_req}, 32'h0);
            chk("st_dinst", dinst, ~32'hC);
            chk("st_pc", pc, 32'h10);
        end
        stall = 1'b0;
        tick();
        chk("st_rel_dinst", dinst, ~32'h10);
        chk("st_rel_pc", pc, 32'h14);
        chk("st_rel_req", {31'b0, u_if.imem_req}, 32'h1);
        tick();
        chk("st_next", dinst, ~32'h14);

        // Redirects: zero wait and 3-cycle latency
        do_branch(4'd0, 2'b01, 32'h100);
        do_branch(4'd3, 2'b01, 32'h100);
        do_branch(4'd3, 2'b10, 32'h200);
        do_branch(4'd3, 2'b11, 32'h300);

        // Reset mid-wait in FETCH
        do_reset(4'd3);
        repeat (5) tick();
        chk("rw_pre_pc", pc, 32'h4);
        resetn = 1'b0;
        #1;
        chk("rw_pc", pc, 32'h0);
        chk("rw_dvalid", {31'b0, dvalid}, 32'h0);
        chk("rw_dinst", dinst, 32'h0);
        chk("rw_dpc4", dpc4, 32'h0);
        chk("rw_req", {31'b0, u_if.imem_req}, 32'h1);
        @(negedge clock);
        resetn = 1'b1;
        repeat (4) tick();
        chk("rw_restart", dinst, ~32'h0);
        chk("rw_restart_pc", pc, 32'h4);

        // Reset mid-HOLD
        do_reset(4'd0);
        repeat (3) tick();
        stall = 1'b1;
        tick();
        chk("rh_hold_req", {31'b0, u_if.imem_req}, 32'h0);
        resetn = 1'b0;
        #1;
        chk("rh_req", {31'b0, u_if.imem_req}, 32'h1);
        chk("rh_pc", pc, 32'h0);
        chk("rh_dinst", dinst, 32'h0);
        chk("rh_dvalid", {31'b0, dvalid}, 32'h0);
        stall = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        tick();
        chk("rh_restart", dinst, ~32'h0);
        chk("rh_restart_v", {31'b0, dvalid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
